unified_mem_arbiter: RTL
========================

Name: unified_mem_arbiter

Overview:
- Shares one single-ported unified memory between the multicycle CPU's instruction-fetch requester and data-memory requester.
- Sequences each access through a fixed-latency memory with a three-state FSM and a wait-state counter.
- Returns read data and a one-cycle acknowledge to the requester that was granted.
- Sits between the control unit/datapath (fetch and load/store phases) and the memory macro.

Parameters:
- AW, 32, address width of both requesters and of the memory port.
- DW, 32, data width.
- WAIT, 2, memory access latency in cycles (legal range 1..15; 0 is illegal).

Ports:
- clk  input  1  clock; all state changes on its rising edge.
- rst  input  1  synchronous reset, active-high.
- if_req  input  1  fetch request; held high until if_ack.
- if_addr  input  AW  fetch address.
- if_rdata  output  DW  fetched instruction; valid while if_ack=1.
- if_ack  output  1  one-cycle completion pulse to fetch requester.
- dm_req  input  1  data request; held high until dm_ack.
- dm_we  input  1  1=store, 0=load.
- dm_addr  input  AW  data address.
- dm_wdata  input  DW  store data.
- dm_rdata  output  DW  load data; valid while dm_ack=1.
- dm_ack  output  1  one-cycle completion pulse to data requester.
- mem_en  output  1  memory enable.
- mem_we  output  1  memory write enable.
- mem_addr  output  AW  memory address.
- mem_wdata  output  DW  memory write data.
- mem_rdata  input  DW  memory read data; valid in the last ACCESS cycle.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous, active-high.
- Reset values: state=IDLE, cnt=0, grant=IF, last_grant=IF, if_ack=0, dm_ack=0, if_rdata=0, dm_rdata=0. mem_en, mem_we and busy read 0 in the cycle after the reset edge.
- IDLE:
  - No request: stay in IDLE; mem_en=0.
  - Any request: select a winner, latch addr, we (forced to 0 for IF) and wdata into internal registers, set grant, load cnt=WAIT-1, go to ACCESS.
- Arbitration without the optional feature: DM has fixed priority over IF when both requests are high.
- ACCESS:
  - mem_en=1; mem_addr/mem_wdata driven from the latched registers; mem_we = latched we.
  - Decrement cnt each cycle.
  - When cnt==0: if the latched we=0, capture mem_rdata into the granted port's rdata register; go to RESP.
  - ACCESS therefore lasts exactly WAIT cycles.
- RESP:
  - mem_en=0, mem_we=0.
  - The granted port's ack=1 for exactly this cycle; the other ack stays 0.
  - Set last_grant=grant; go to IDLE.
- Latency: a request sampled in IDLE at cycle t produces ack in cycle t+1+WAIT. Back-to-back accesses cost WAIT+2 cycles each.
- Requester rule: keep req, addr, wdata and we stable until the ack cycle. Drop req in the cycle after ack unless issuing a new request; a req still high in IDLE is treated as a new request.
- A losing requester keeps req high and is served next; it is never dropped.
- rdata registers change only on a read capture. A store leaves dm_rdata unchanged; if_rdata holds its value between fetches.
- mem_* outputs are don't-care when mem_en=0, but mem_we must be 0 whenever mem_en=0.
- Request input changes during ACCESS/RESP have no effect; the latched values are used.
- Reset mid-ACCESS: the access is aborted, no ack is issued, and mem_en=0 from the next cycle. A partially performed store is the memory's responsibility.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: on a simultaneous if_req and dm_req in IDLE, grant the port that is not last_grant (round-robin). A single request is granted directly.
- Undefined: fixed DM-over-IF priority. last_grant is still maintained but unused.

Test Plan:
- Reset then idle: assert rst 2 cycles, release, no req for 5 cycles -> mem_en=0, if_ack=dm_ack=0, busy=0 throughout.
- Single fetch, WAIT=2: if_addr=0x0000_3000, memory returns 0x3402_0005 -> mem_en high exactly 2 cycles with mem_addr=0x3000 and mem_we=0; if_ack high 3 cycles after the request cycle; if_rdata=0x3402_0005.
- Store then load: dm_we=1, dm_addr=0x10, dm_wdata=0xDEAD_BEEF -> mem_we=1 for 2 cycles, dm_ack pulse, dm_rdata unchanged. Then a load from 0x10 -> dm_rdata=0xDEAD_BEEF.
- Simultaneous requests, macro undefined: if_req=dm_req=1 in the same IDLE cycle -> dm_ack first, if_ack WAIT+2 cycles later.
- Simultaneous requests, MEM_ARB_RR_EN defined: last_grant=DM, both requesters continuously requesting -> grants alternate IF, DM, IF, DM over 4 accesses.
- Reset mid-operation: rst asserted in the first ACCESS cycle of a load -> no dm_ack, mem_en=0 next cycle, state returns to IDLE; a fresh load then completes normally.

Source files
------------

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one fixed-latency memory between fetch (IF) and data (DM) requesters.
// Define MEM_ARB_RR_EN for round-robin on simultaneous requests; default is DM-over-IF priority.
module unified_mem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int WAIT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ack,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_ack,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  localparam logic [3:0] CNT_INIT = 4'(WAIT - 1);
`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  state_t state, state_n;
  logic [3:0] cnt;
  logic grant, last_grant;
  logic [AW-1:0] a_addr;
  logic a_we;
  logic [DW-1:0] a_wdata;
  logic pick_dm, start;
  // grant/last_grant: 1 = DM, 0 = IF; with RR a tie goes to the port not served last
  assign pick_dm = dm_req && (!if_req || !RR || !last_grant);
  assign start = state == IDLE && (if_req || dm_req);
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (start ? ACCESS : IDLE) :
              state == ACCESS ? (cnt == 4'd0 ? RESP : ACCESS) : IDLE;
  end
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 4'd0;
      grant <= 1'b0;
      last_grant <= 1'b0;
      if_rdata <= '0;
      dm_rdata <= '0;
    end else begin
      if (start) begin
        grant <= pick_dm;
        a_addr <= pick_dm ? dm_addr : if_addr;
        a_we <= pick_dm && dm_we;
        a_wdata <= dm_wdata;
        cnt <= CNT_INIT;
      end
      if (state == ACCESS) begin
        cnt <= cnt - 4'd1;
        if (cnt == 4'd0 && !a_we && grant) dm_rdata <= mem_rdata;
        if (cnt == 4'd0 && !a_we && !grant) if_rdata <= mem_rdata;
      end
      if (state == RESP) last_grant <= grant;
    end
  end
  assign mem_en = state == ACCESS;
  assign mem_we = mem_en && a_we;
  assign mem_addr = a_addr;
  assign mem_wdata = a_wdata;
  assign if_ack = state == RESP && !grant;
  assign dm_ack = state == RESP && grant;
  assign busy = state != IDLE;
endmodule
